// File: rtl/hazard_scoreboard_if.sv
// Bundle between the ID stage and the hazard scoreboard: decoded operand info
// in, stall/forwarding decisions out.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 4,
  parameter int FWD_DEPTH  = 2,
  parameter int STAT_W     = 16
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  // Handshake: id_valid offers the instruction in ID and stall is the inverse
  // of ready. The instruction issues on a cycle with id_valid=1 and stall=0;
  // otherwise ID must present it again.
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_use1;
  logic                  id_use2;
  logic                  id_writes;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_is_load;
  logic                  ex_flush;
  logic                  stall;
  logic                  if_id_hold;
  logic                  id_ex_bubble;
  logic [SEL_W-1:0]      fwd_sel1;
  logic [SEL_W-1:0]      fwd_sel2;
  logic [STAT_W-1:0]     stall_count;

  modport master (
    output id_valid, id_src1, id_src2, id_use1, id_use2, id_writes, id_dest,
           id_is_load, ex_flush,
    input  stall, if_id_hold, id_ex_bubble, fwd_sel1, fwd_sel2, stall_count
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_use1, id_use2, id_writes, id_dest,
           id_is_load, ex_flush,
    output stall, if_id_hold, id_ex_bubble, fwd_sel1, fwd_sel2, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: per-register bubble countdown for stalls plus a shift
// register of in-flight destination tags for operand forwarding selects.
module hazard_scoreboard #(
  parameter int REG_ADDR_W   = 4,
  parameter int ALU_BUBBLES  = 0,
  parameter int LOAD_BUBBLES = 1,
  parameter int FWD_DEPTH    = 2,
  parameter int ZERO_REG     = 1,
  parameter int STAT_W       = 16
) (
  input logic              clock,
  input logic              reset,
  hazard_scoreboard_if.slave bus
);
  localparam int NREGS = 2 ** REG_ADDR_W;
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  typedef logic [REG_ADDR_W-1:0] reg_t;

  logic [2:0]        cnt [NREGS];
  logic [FWD_DEPTH:1] tag_v;
  reg_t              tag_d [1:FWD_DEPTH];
  logic [STAT_W-1:0] stat_q;

  logic             dep1, dep2, stall, issue, wr_en, flush_clr;
  logic [SEL_W-1:0] sel1, sel2;

  function automatic logic is_zero(input reg_t r);
    return (ZERO_REG != 0) && (r == '0);
  endfunction

  always_comb begin
    dep1      = bus.id_use1 && !is_zero(bus.id_src1) && (cnt[bus.id_src1] != 3'd0);
    dep2      = bus.id_use2 && !is_zero(bus.id_src2) && (cnt[bus.id_src2] != 3'd0);
    stall     = bus.id_valid && (dep1 || dep2);
    issue     = bus.id_valid && !stall;
    wr_en     = issue && bus.id_writes && !is_zero(bus.id_dest);
    flush_clr = bus.ex_flush && tag_v[1];
  end

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (tag_v[k] && (tag_d[k] == bus.id_src1)) sel1 = SEL_W'(k);
      if (tag_v[k] && (tag_d[k] == bus.id_src2)) sel2 = SEL_W'(k);
    end
    if (!bus.id_use1 || is_zero(bus.id_src1)) sel1 = '0;
    if (!bus.id_use2 || is_zero(bus.id_src2)) sel2 = '0;
  end

  // A new writer's load beats a flush clear, which beats the decrement.
  always_ff @(posedge clock) begin
    for (int r = 0; r < NREGS; r++) begin
      if (reset) begin
        cnt[r] <= 3'd0;
      end else if (wr_en && (bus.id_dest == reg_t'(r))) begin
        cnt[r] <= bus.id_is_load ? 3'(LOAD_BUBBLES) : 3'(ALU_BUBBLES);
      end else if (flush_clr && (tag_d[1] == reg_t'(r))) begin
        cnt[r] <= 3'd0;
      end else if (cnt[r] != 3'd0) begin
        cnt[r] <= cnt[r] - 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_v <= '0;
      for (int k = 1; k <= FWD_DEPTH; k++) tag_d[k] <= '0;
    end else begin
      tag_v[1] <= issue && bus.id_writes;
      tag_d[1] <= bus.id_dest;
      for (int k = 2; k <= FWD_DEPTH; k++) begin
        tag_v[k] <= tag_v[k-1] && !((k == 2) && bus.ex_flush);
        tag_d[k] <= tag_d[k-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_q <= '0;
    end else if (stall && (stat_q != '1)) begin
      stat_q <= stat_q + 1'b1;
    end
  end

  assign bus.stall        = stall;
  assign bus.if_id_hold   = stall;
  assign bus.id_ex_bubble = stall;
  assign bus.fwd_sel1     = sel1;
  assign bus.fwd_sel2     = sel2;
  assign bus.stall_count  = stat_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic, checked
// every cycle against a cycle-numbered model of writer readiness and issue history.
module tb_hazard_scoreboard;
  localparam int RAW = 4;
  localparam int AB  = 0;
  localparam int LB  = 1;
  localparam int FD  = 2;
  localparam int ZR  = 1;
  localparam int SW  = 6;
  localparam int NR  = 2 ** RAW;
  localparam int MAXC = 4096;
  localparam int SAT  = (1 << SW) - 1;

  logic clock;
  logic reset;

  hazard_scoreboard_if #(.REG_ADDR_W(RAW), .FWD_DEPTH(FD), .STAT_W(SW)) bus ();

  hazard_scoreboard #(
    .REG_ADDR_W(RAW), .ALU_BUBBLES(AB), .LOAD_BUBBLES(LB),
    .FWD_DEPTH(FD), .ZERO_REG(ZR), .STAT_W(SW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model: cycle at which each register's youngest writer is usable,
  // plus a per-cycle record of what issued and what was squashed
  int  cyc;
  int  last_rst;
  int  free_at [NR];
  bit  wv [MAXC];
  int  wd [MAXC];
  bit  killed [MAXC];
  int  m_count;
  bit  armed;

  int  checks;
  int  errors;
  int  obs_stall, obs_f1, obs_f2, obs_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int fwd_exp(input bit u, input int s);
    if (!u || (ZR != 0 && s == 0)) return 0;
    for (int k = 1; k <= FD; k++) begin
      int ic;
      ic = cyc - k;
      if (ic > last_rst && wv[ic] && !killed[ic] && wd[ic] == s) return k;
    end
    return 0;
  endfunction

  function automatic bit dep_exp(input bit u, input int s);
    if (!u || (ZR != 0 && s == 0)) return 1'b0;
    return cyc < free_at[s];
  endfunction

  // driver task: present one cycle of ID inputs, check, then advance the model
  task automatic step(input bit v, input int s1, input int s2, input bit u1, input bit u2,
                      input bit w, input int d, input bit ld, input bit fl, input bit rs);
    bit e_stall, e_issue;
    int e_f1, e_f2;
    @(negedge clock);
    reset          = rs;
    bus.id_valid   = v;
    bus.id_src1    = RAW'(s1);
    bus.id_src2    = RAW'(s2);
    bus.id_use1    = u1;
    bus.id_use2    = u2;
    bus.id_writes  = w;
    bus.id_dest    = RAW'(d);
    bus.id_is_load = ld;
    bus.ex_flush   = fl;
    #1;
    e_stall = v && (dep_exp(u1, s1) || dep_exp(u2, s2));
    e_f1    = fwd_exp(u1, s1);
    e_f2    = fwd_exp(u2, s2);
    obs_stall = int'(bus.stall);
    obs_f1    = int'(bus.fwd_sel1);
    obs_f2    = int'(bus.fwd_sel2);
    obs_cnt   = int'(bus.stall_count);
    if (armed) begin
      check("stall", 32'(bus.stall), 32'(e_stall));
      check("hold", 32'(bus.if_id_hold), 32'(e_stall));
      check("bubble", 32'(bus.id_ex_bubble), 32'(e_stall));
      check("fwd1", 32'(bus.fwd_sel1), 32'(e_f1));
      check("fwd2", 32'(bus.fwd_sel2), 32'(e_f2));
      check("stat", 32'(bus.stall_count), 32'(m_count));
    end
    if (rs) begin
      for (int r = 0; r < NR; r++) free_at[r] = 0;
      last_rst = cyc;
      wv[cyc]  = 1'b0;
      m_count  = 0;
    end else begin
      if (fl && (cyc - 1) > last_rst && wv[cyc-1] && !killed[cyc-1]) begin
        killed[cyc-1] = 1'b1;
        free_at[wd[cyc-1]] = cyc + 1;
      end
      e_issue = v && !e_stall;
      wv[cyc] = e_issue && w;
      wd[cyc] = d;
      if (e_issue && w && !(ZR != 0 && d == 0))
        free_at[d] = cyc + (ld ? LB : AB) + 1;
      if (e_stall && m_count < SAT) m_count++;
    end
    armed = 1'b1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    checks = 0; errors = 0; m_count = 0; armed = 1'b0;
    cyc = 8; last_rst = 0;
    for (int r = 0; r < NR; r++) free_at[r] = 0;
    reset = 1'b1;

    // reset with garbage inputs
    step(1, 3, 9, 1, 1, 1, 4, 1, 1, 1);
    step(1, 5, 2, 1, 1, 1, 6, 0, 1, 1);
    step(1, 7, 7, 1, 1, 1, 7, 1, 1, 0);
    check("rst_stall", 32'(obs_stall), 32'd0);
    check("rst_fwd1", 32'(obs_f1), 32'd0);
    check("rst_fwd2", 32'(obs_f2), 32'd0);
    check("rst_stat", 32'(obs_cnt), 32'd0);
    idle(3);

    // load r3 then dependent: one stall cycle, then forward from stage 2
    step(1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
    step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    check("ld_stall", 32'(obs_stall), 32'd1);
    step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    check("ld_issue", 32'(obs_stall), 32'd0);
    check("ld_fwd", 32'(obs_f1), 32'd2);
    check("ld_stat", 32'(obs_cnt), 32'd1);

    // ALU r5 then readers at distance 1, 2, 3
    step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    step(1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
    check("alu_stall", 32'(obs_stall), 32'd0);
    check("alu_fwd_d1", 32'(obs_f2), 32'd1);
    step(1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
    check("alu_fwd_d2", 32'(obs_f2), 32'd2);
    step(1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
    check("alu_fwd_d3", 32'(obs_f2), 32'd0);

    // writes to r0 never hazard nor forward
    step(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    check("r0_stall", 32'(obs_stall), 32'd0);
    check("r0_fwd", 32'(obs_f1), 32'd0);
    idle(2);

    // load r7 squashed in EX while its dependent waits in ID
    step(1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
    step(1, 7, 0, 1, 0, 0, 0, 0, 1, 0);
    check("fl_stall_pre", 32'(obs_stall), 32'd1);
    step(1, 7, 0, 1, 0, 0, 0, 0, 0, 0);
    check("fl_stall", 32'(obs_stall), 32'd0);
    check("fl_fwd", 32'(obs_f1), 32'd0);
    idle(2);

    // two writers to r2 back to back: youngest forwards
    step(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    step(1, 2, 2, 1, 1, 0, 0, 0, 0, 0);
    check("ww_fwd1", 32'(obs_f1), 32'd1);
    check("ww_fwd2", 32'(obs_f2), 32'd1);
    idle(2);

    // reset asserted mid-stall
    step(1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
    step(1, 3, 0, 1, 0, 0, 0, 0, 0, 1);
    check("rs_mid_stall", 32'(obs_stall), 32'd1);
    step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    check("rs_after_stall", 32'(obs_stall), 32'd0);
    check("rs_after_fwd", 32'(obs_f1), 32'd0);
    check("rs_after_stat", 32'(obs_cnt), 32'd0);

    // repeated load-use stalls drive the statistic into saturation
    for (int i = 0; i < SAT + 6; i++) begin
      step(1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
      step(1, 0, 4, 0, 1, 0, 0, 0, 0, 0);
      step(1, 0, 4, 0, 1, 0, 0, 0, 0, 0);
    end
    check("stat_sat", 32'(obs_cnt), 32'(SAT));
    step(1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
    step(1, 0, 4, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("stat_nowrap", 32'(obs_cnt), 32'(SAT));

    // random traffic over a small register window to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0, int'($urandom_range(0, 7)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
